// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, clear, load and wrap-or-saturate at the range ends.
// Define UDC_STICKY_EN to add the err_clr input and the sticky overflow/underflow flag err_sticky.
module updown_counter_param #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             updown,
`ifdef UDC_STICKY_EN
   input  logic             err_clr,
   output logic             err_sticky,
`endif
   output logic [WIDTH-1:0] qout,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   logic [WIDTH-1:0] q_nxt;
   logic             ovf_nxt;
   logic             unf_nxt;
   logic             at_top;
   logic             at_bot;

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

   // Value taken when a step runs past a range end: hold in saturate mode, else wrap.
   function automatic logic [WIDTH-1:0] end_value(input logic [WIDTH-1:0] hold_v,
                                                  input logic [WIDTH-1:0] wrap_v);
      return SATURATE ? hold_v : wrap_v;
   endfunction

   assign at_top = (qout == MAX_VAL);
   assign at_bot = (qout == '0);
   assign tc     = en & ~clr & ~load & ((~updown & at_top) | (updown & at_bot));

   always_comb begin
      q_nxt   = qout;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (clr) begin
         q_nxt = '0;
      end else if (load) begin
         q_nxt = clamp_load(load_val);
      end else if (en) begin
         if (!updown) begin
            if (at_top) begin
               ovf_nxt = 1'b1;
               q_nxt   = end_value(MAX_VAL, '0);
            end else begin
               q_nxt = qout + WIDTH'(1);
            end
         end else begin
            if (at_bot) begin
               unf_nxt = 1'b1;
               q_nxt   = end_value('0, MAX_VAL);
            end else begin
               q_nxt = qout - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qout <= '0;
         ovf  <= 1'b0;
         unf  <= 1'b0;
      end else begin
         qout <= q_nxt;
         ovf  <= ovf_nxt;
         unf  <= unf_nxt;
      end
   end

`ifdef UDC_STICKY_EN
   // Set is taken from the same edge that raises ovf/unf, so a coincident clear loses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_sticky <= 1'b0;
      end else if (ovf_nxt | unf_nxt) begin
         err_sticky <= 1'b1;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: three configurations share one stimulus stream.
// Honours UDC_STICKY_EN the same way as the design.
module tb_updown_counter_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, clr, load, en, updown, err_clr;
   logic [7:0] load_val;
   logic [7:0] q0, q1, q2;
   logic       tc0, tc1, tc2, ov0, ov1, ov2, un0, un1, un2, st0, st1, st2;

   updown_counter_param dut0 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .updown(updown),
`ifdef UDC_STICKY_EN
      .err_clr(err_clr), .err_sticky(st0),
`endif
      .qout(q0), .tc(tc0), .ovf(ov0), .unf(un0));

   updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .updown(updown),
`ifdef UDC_STICKY_EN
      .err_clr(err_clr), .err_sticky(st1),
`endif
      .qout(q1), .tc(tc1), .ovf(ov1), .unf(un1));

   updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b1)) dut2 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .updown(updown),
`ifdef UDC_STICKY_EN
      .err_clr(err_clr), .err_sticky(st2),
`endif
      .qout(q2), .tc(tc2), .ovf(ov2), .unf(un2));

`ifndef UDC_STICKY_EN
   assign st0 = 1'b0;
   assign st1 = 1'b0;
   assign st2 = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] q;
      logic       o;
      logic       u;
      logic       t;
      logic       s;
   } obs_t;

   typedef struct {
      int unsigned q;
      bit          o;
      bit          u;
      bit          s;
   } mst_t;

   obs_t act0, act1, act2;
   assign act0 = {q0, ov0, un0, tc0, st0};
   assign act1 = {q1, ov1, un1, tc1, st1};
   assign act2 = {q2, ov2, un2, tc2, st2};

   obs_t        sbq[$];
   mst_t        m[3];
   int unsigned mx[3];
   bit          sat[3];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Reference behaviour straight from the counting rules, using plain integers.
   function automatic mst_t step(input mst_t c, input int unsigned top, input bit s_mode,
                                 input bit c_i, input bit l_i, input int unsigned lv,
                                 input bit e_i, input bit dn, input bit ec);
      mst_t n = c;
      n.o = 1'b0;
      n.u = 1'b0;
      if (c_i)      n.q = 0;
      else if (l_i) n.q = (lv > top) ? top : lv;
      else if (e_i) begin
         if (!dn) begin
            if (c.q == top) begin n.o = 1'b1; n.q = s_mode ? top : 0; end
            else n.q = c.q + 1;
         end else begin
            if (c.q == 0) begin n.u = 1'b1; n.q = s_mode ? 0 : top; end
            else n.q = c.q - 1;
         end
      end
      if (n.o || n.u) n.s = 1'b1;
      else if (ec)    n.s = 1'b0;
      return n;
   endfunction

   always @(negedge clk) begin
      obs_t e, a;
      if (sbq.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            e = sbq.pop_front();
            a = (k == 0) ? act0 : (k == 1) ? act1 : act2;
            chk("qout", k, 32'(a.q), 32'(e.q));
            chk("ovf",  k, 32'(a.o), 32'(e.o));
            chk("unf",  k, 32'(a.u), 32'(e.u));
            chk("tc",   k, 32'(a.t), 32'(e.t));
`ifdef UDC_STICKY_EN
            chk("err_sticky", k, 32'(a.s), 32'(e.s));
`endif
         end
      end
   end

   // Called just after a rising edge: apply inputs, queue what the DUTs show this cycle,
   // then advance the model across the next edge.
   task automatic drive(input bit c, input bit l, input logic [7:0] lv,
                        input bit e, input bit d, input bit ec);
      bit t;
      clr = c; load = l; load_val = lv; en = e; updown = d; err_clr = ec;
      for (int k = 0; k < 3; k++) begin
         t = e && !c && !l && ((!d && m[k].q == mx[k]) || (d && m[k].q == 0));
         sbq.push_back({8'(m[k].q), m[k].o, m[k].u, t, m[k].s});
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         m[k] = step(m[k], mx[k], sat[k], c, l, int'(lv), e, d, ec);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_q"},   0, 32'(q0),  0);
      chk({nm, "_q"},   1, 32'(q1),  0);
      chk({nm, "_q"},   2, 32'(q2),  0);
      chk({nm, "_ovf"}, 0, 32'(ov0), 0);
      chk({nm, "_ovf"}, 1, 32'(ov1), 0);
      chk({nm, "_ovf"}, 2, 32'(ov2), 0);
      chk({nm, "_unf"}, 0, 32'(un0), 0);
      chk({nm, "_unf"}, 1, 32'(un1), 0);
      chk({nm, "_unf"}, 2, 32'(un2), 0);
`ifdef UDC_STICKY_EN
      chk({nm, "_sticky"}, 0, 32'(st0), 0);
      chk({nm, "_sticky"}, 1, 32'(st1), 0);
      chk({nm, "_sticky"}, 2, 32'(st2), 0);
`endif
   endtask

   // Reset pulse between edges; outputs must clear without a clock.
   task automatic reset_mid();
      #1 reset_n = 1'b0;
      #1;
      check_zero("async_rst");
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) m[k] = '{0, 1'b0, 1'b0, 1'b0};
   endtask

   initial begin
      logic [7:0] lv;
      mx[0] = 255; mx[1] = 9; mx[2] = 9;
      sat[0] = 1'b0; sat[1] = 1'b0; sat[2] = 1'b1;
      reset_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; updown = 1'b0;
      err_clr = 1'b0; load_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) m[k] = '{0, 1'b0, 1'b0, 1'b0};

      repeat (260) drive(0, 0, 8'd0, 1, 0, 0);
      drive(0, 1, 8'd3, 0, 0, 0);
      repeat (5) drive(0, 0, 8'd0, 1, 1, 0);
      drive(0, 1, 8'd20, 0, 0, 0);
      repeat (3) drive(0, 0, 8'd0, 1, 0, 0);
      drive(1, 1, 8'd5, 1, 0, 0);
      drive(0, 1, 8'd5, 1, 0, 0);
      drive(0, 0, 8'd0, 0, 0, 0);
      drive(0, 1, 8'h7E, 0, 0, 0);
      reset_mid();
      repeat (3) drive(0, 0, 8'd0, 1, 0, 0);

      drive(0, 1, 8'hFF, 0, 0, 0);
      drive(0, 0, 8'd0, 1, 0, 0);
      repeat (10) drive(0, 0, 8'd0, 0, 0, 0);
      drive(0, 1, 8'hFF, 0, 0, 0);
      drive(0, 0, 8'd0, 1, 0, 1);
      drive(0, 0, 8'd0, 0, 0, 1);
      repeat (2) drive(0, 0, 8'd0, 0, 0, 0);
      drive(0, 0, 8'd0, 1, 1, 0);
      drive(0, 0, 8'd0, 1, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) reset_mid();
         lv = 8'($urandom);
         if ($urandom_range(0, 3) == 0) lv = 8'hFF - 8'($urandom_range(0, 2));
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, lv,
               $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 0, 32'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
